// File: rtl/lifo_fifo_buf_pkg.sv
// Shared definitions for the LIFO/FIFO circular buffer: pop-mode encoding,
// modulo-DEPTH pointer stepping and register width helpers.
package lifo_fifo_pkg;

   localparam logic MODE_LIFO = 1'b0;
   localparam logic MODE_FIFO = 1'b1;

   // Advance a pointer by one, wrapping from depth-1 back to 0.
   function automatic int ptr_inc(input int p, input int depth);
      return (p == depth - 1) ? 0 : p + 1;
   endfunction

   // Step a pointer back by one, wrapping from 0 to depth-1.
   function automatic int ptr_dec(input int p, input int depth);
      return (p == 0) ? depth - 1 : p - 1;
   endfunction

   // Width of an occupancy counter able to hold 0..depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a pointer addressing 0..depth-1.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/lifo_fifo_buf_if.sv
// Request/response bundle between the producer/consumer logic (master)
// and the LIFO/FIFO buffer (slave).
interface lifo_fifo_buf_if
   import lifo_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 3,
   parameter int DEPTH      = 5
);
   localparam int CW = cnt_w(DEPTH);

   logic                  push;
   logic                  pop;
   logic                  mode;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  stack_full;
   logic                  stack_empty;
   logic                  stack_threshold;
   logic                  error;
   logic [CW-1:0]         count;

   modport master (
      output push, pop, mode, data_in,
      input  data_out, data_valid, stack_full, stack_empty,
             stack_threshold, error, count
   );

   modport slave (
      input  push, pop, mode, data_in,
      output data_out, data_valid, stack_full, stack_empty,
             stack_threshold, error, count
   );
endinterface

// File: rtl/lifo_fifo_buf_ptr_ctr.sv
// Modulo-DEPTH up/down pointer register used for the read and write
// pointers of the circular buffer.
module buf_ptr_ctr
   import lifo_fifo_pkg::*;
#(
   parameter int DEPTH = 5,
   parameter int PW    = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   output logic [PW-1:0] ptr
);

   // Step the pointer with wrap-around; inc and dec together cancel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (inc && !dec) begin
         ptr <= PW'(ptr_inc(int'(ptr), DEPTH));
      end else if (dec && !inc) begin
         ptr <= PW'(ptr_dec(int'(ptr), DEPTH));
      end
   end

endmodule

// File: rtl/lifo_fifo_buf.sv
// Circular-buffer store poppable as a stack (LIFO) or a queue (FIFO),
// chosen per pop by mode. Registered data_out with a one-cycle valid strobe,
// occupancy count and flags decoded from the registered count.
// Optional build macro LIFO_FIFO_OVERWRITE_EN: a push into a full buffer
// without a pop drops the oldest entry instead of raising error.
module lifo_fifo_buf
   import lifo_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 3,
   parameter int DEPTH      = 5,
   parameter int THRESHOLD  = 3
) (
   input  logic           clk,
   input  logic           rst,
   lifo_fifo_buf_if.slave bus
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] THR_CNT  = CW'(THRESHOLD);
`ifdef LIFO_FIFO_OVERWRITE_EN
   localparam logic OVERWRITE = 1'b1;
`else
   localparam logic OVERWRITE = 1'b0;
`endif

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         rd_ptr, wr_ptr, top_ptr, rd_addr, wr_addr;
   logic [CW-1:0]         count_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  vld_q, err_q;
   logic                  full, empty, fifo_sel;
   logic                  do_pop, do_push, ovw, lifo_swap, req_err;
   logic                  rd_inc, wr_inc, wr_dec;

   // Decode the request against the current occupancy into pointer moves.
   always_comb begin
      full      = (count_q == FULL_CNT);
      empty     = (count_q == '0);
      fifo_sel  = (bus.mode == MODE_FIFO);
      top_ptr   = PW'(ptr_dec(int'(wr_ptr), DEPTH));
      do_pop    = bus.pop && !empty;
      // A full buffer still accepts a push when a pop frees a slot the same cycle.
      do_push   = bus.push && (!full || bus.pop || OVERWRITE);
      ovw       = OVERWRITE && bus.push && !bus.pop && full;
      req_err   = (bus.pop && empty) || (bus.push && !bus.pop && full && !OVERWRITE);
      // LIFO push+pop replaces the top entry in place, leaving wr_ptr alone.
      lifo_swap = do_push && do_pop && !fifo_sel;
      wr_inc    = do_push && !lifo_swap;
      wr_dec    = do_pop && !fifo_sel && !do_push;
      rd_inc    = (do_pop && fifo_sel) || ovw;
      rd_addr   = fifo_sel ? rd_ptr : top_ptr;
      wr_addr   = lifo_swap ? top_ptr : wr_ptr;
   end

   buf_ptr_ctr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (rd_inc),
      .dec (1'b0),
      .ptr (rd_ptr)
   );

   buf_ptr_ctr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (wr_inc),
      .dec (wr_dec),
      .ptr (wr_ptr)
   );

   // Storage is never reset; only accepted pushes write it.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_addr] <= bus.data_in;
      end
   end

   // Occupancy: overwrite and push+pop leave it unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (do_push && !do_pop && !ovw) begin
         count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_q <= count_q - CW'(1);
      end
   end

   // Registered pop data, its valid strobe and the error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q <= '0;
         vld_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         vld_q <= do_pop;
         err_q <= req_err;
         if (do_pop) begin
            dout_q <= mem[rd_addr];
         end
      end
   end

   assign bus.data_out        = dout_q;
   assign bus.data_valid      = vld_q;
   assign bus.error           = err_q;
   assign bus.count           = count_q;
   assign bus.stack_full      = full;
   assign bus.stack_empty     = empty;
   assign bus.stack_threshold = (count_q >= THR_CNT);

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Directed-vector bench for lifo_fifo_buf (DATA_WIDTH=3, DEPTH=5, THRESHOLD=3).
// Expectations for the full-buffer push follow LIFO_FIFO_OVERWRITE_EN.
module tb_lifo_fifo_buf;
   import lifo_fifo_pkg::*;

   localparam int W = 3;
   localparam int D = 5;
   localparam int T = 3;

   typedef struct {
      logic         push;
      logic         pop;
      logic         mode;
      logic [W-1:0] din;
      logic [W-1:0] dout;
      logic         vld;
      int           cnt;
      logic         err;
   } vec_t;

`ifdef LIFO_FIFO_OVERWRITE_EN
   localparam int FIRST = 2;
   localparam logic FULL_ERR = 1'b0;
`else
   localparam int FIRST = 1;
   localparam logic FULL_ERR = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   vec_t tbl[$];

   lifo_fifo_buf_if #(.DATA_WIDTH(W), .DEPTH(D)) bus ();

   lifo_fifo_buf #(.DATA_WIDTH(W), .DEPTH(D), .THRESHOLD(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached total=%0d", total);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic pu, input logic po, input logic md, input int di,
                               input int dout, input logic vld, input int cnt, input logic err);
      vec_t v;
      v.push = pu;
      v.pop  = po;
      v.mode = md;
      v.din  = di[W-1:0];
      v.dout = dout[W-1:0];
      v.vld  = vld;
      v.cnt  = cnt;
      v.err  = err;
      return v;
   endfunction

   task automatic add(input logic pu, input logic po, input logic md, input int di,
                      input int dout, input logic vld, input int cnt, input logic err);
      tbl.push_back(mk(pu, po, md, di, dout, vld, cnt, err));
   endtask

   task automatic check_out(input string tag, input vec_t v);
      chk({tag, "_dout"},  int'(bus.data_out), int'(v.dout));
      chk({tag, "_valid"}, int'(bus.data_valid), int'(v.vld));
      chk({tag, "_count"}, int'(bus.count), v.cnt);
      chk({tag, "_err"},   int'(bus.error), int'(v.err));
      chk({tag, "_full"},  int'(bus.stack_full), (v.cnt == D) ? 1 : 0);
      chk({tag, "_empty"}, int'(bus.stack_empty), (v.cnt == 0) ? 1 : 0);
      chk({tag, "_thr"},   int'(bus.stack_threshold), (v.cnt >= T) ? 1 : 0);
   endtask

   task automatic do_vec(input vec_t v, input string tag);
      bus.push    = v.push;
      bus.pop     = v.pop;
      bus.mode    = v.mode;
      bus.data_in = v.din;
      @(posedge clk);
      #1;
      check_out(tag, v);
   endtask

   initial begin
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.mode = MODE_FIFO;
      bus.data_in = '0;

      // FIFO fill and drain, then a quiet cycle to see the strobe drop
      for (int i = 1; i <= 5; i++) add(1, 0, MODE_FIFO, i, 0, 0, i, 0);
      for (int i = 1; i <= 5; i++) add(0, 1, MODE_FIFO, 0, i, 1, 5 - i, 0);
      add(0, 0, MODE_FIFO, 0, 5, 0, 0, 0);
      // LIFO fill and drain, pop on empty, error gone next cycle
      for (int i = 1; i <= 5; i++) add(1, 0, MODE_LIFO, i, 5, 0, i, 0);
      for (int i = 1; i <= 5; i++) add(0, 1, MODE_LIFO, 0, 6 - i, 1, 5 - i, 0);
      add(0, 1, MODE_LIFO, 0, 1, 0, 0, 1);
      add(0, 0, MODE_LIFO, 0, 1, 0, 0, 0);
      // FIFO wrap past the last index
      for (int i = 1; i <= 5; i++) add(1, 0, MODE_FIFO, i, 1, 0, i, 0);
      for (int i = 1; i <= 3; i++) add(0, 1, MODE_FIFO, 0, i, 1, 5 - i, 0);
      add(1, 0, MODE_FIFO, 6, 3, 0, 3, 0);
      add(1, 0, MODE_FIFO, 7, 3, 0, 4, 0);
      add(1, 0, MODE_FIFO, 0, 3, 0, 5, 0);
      add(0, 1, MODE_FIFO, 0, 4, 1, 4, 0);
      add(0, 1, MODE_FIFO, 0, 5, 1, 3, 0);
      add(0, 1, MODE_FIFO, 0, 6, 1, 2, 0);
      add(0, 1, MODE_FIFO, 0, 7, 1, 1, 0);
      add(0, 1, MODE_FIFO, 0, 0, 1, 0, 0);
      // LIFO push+pop replaces the top
      add(1, 0, MODE_LIFO, 1, 0, 0, 1, 0);
      add(1, 0, MODE_LIFO, 2, 0, 0, 2, 0);
      add(1, 1, MODE_LIFO, 7, 2, 1, 2, 0);
      add(0, 1, MODE_LIFO, 0, 7, 1, 1, 0);
      add(0, 1, MODE_LIFO, 0, 1, 1, 0, 0);
      // FIFO push+pop while full
      for (int i = 1; i <= 5; i++) add(1, 0, MODE_FIFO, i, 1, 0, i, 0);
      add(1, 1, MODE_FIFO, 6, 1, 1, 5, 0);
      for (int i = 2; i <= 6; i++) add(0, 1, MODE_FIFO, 0, i, 1, 6 - i, 0);
      // push+pop on empty: push lands, pop rejected
      add(1, 1, MODE_FIFO, 3, 6, 0, 1, 1);
      add(0, 1, MODE_FIFO, 0, 3, 1, 0, 0);
      // mode switched between pops of the same contents
      add(1, 0, MODE_FIFO, 4, 3, 0, 1, 0);
      add(1, 0, MODE_FIFO, 5, 3, 0, 2, 0);
      add(1, 0, MODE_FIFO, 6, 3, 0, 3, 0);
      add(0, 1, MODE_LIFO, 0, 6, 1, 2, 0);
      add(0, 1, MODE_FIFO, 0, 4, 1, 1, 0);
      add(0, 1, MODE_LIFO, 0, 5, 1, 0, 0);

      // reset values, checked without any clock edge involved
      #1 rst = 1'b0;
      #2;
      check_out("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
      #9 rst = 1'b1;

      foreach (tbl[i]) do_vec(tbl[i], $sformatf("v%0d", i));

      // push into a full buffer without a pop
      for (int i = 1; i <= 5; i++) do_vec(mk(1, 0, MODE_FIFO, i, 5, 0, i, 0), $sformatf("fill%0d", i));
      do_vec(mk(1, 0, MODE_FIFO, 6, 5, 0, 5, FULL_ERR), "full_push");
      do_vec(mk(0, 0, MODE_FIFO, 0, 5, 0, 5, 0), "full_idle");
      for (int i = 0; i < 5; i++) do_vec(mk(0, 1, MODE_FIFO, 0, FIRST + i, 1, 4 - i, 0), $sformatf("full_pop%0d", i));

      // asynchronous reset in the middle of a cycle with a strobe in flight
      for (int i = 1; i <= 5; i++) do_vec(mk(1, 0, MODE_FIFO, i, FIRST + 4, 0, i, 0), $sformatf("refill%0d", i));
      do_vec(mk(0, 1, MODE_FIFO, 0, 1, 1, 4, 0), "pre_rst_pop");
      bus.pop = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_out("mid_rst", mk(0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      do_vec(mk(1, 0, MODE_FIFO, 2, 0, 0, 1, 0), "post_rst_push");
      do_vec(mk(0, 1, MODE_FIFO, 0, 2, 1, 0, 0), "post_rst_pop");

      bus.push = 1'b0;
      bus.pop = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lifo_fifo_buf.md
Name: lifo_fifo_buf

Overview:
- Parametrised successor of the fixed 3-bit/5-location stack.
- Single circular-buffer store, runtime-selectable as LIFO (stack) or FIFO (queue) per pop.
- Adds: generic width/depth/threshold, simultaneous push+pop, registered data_out with valid strobe, occupancy count.
- Sits between producer/consumer logic in the same datapath slot as the existing stack wrappers.

Parameters:
- DATA_WIDTH, 3, bits per entry.
- DEPTH, 5, number of entries; any value >= 2, not restricted to powers of two.
- THRESHOLD, 3, stack_threshold asserts when count >= THRESHOLD; legal range 1..DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- push  input  1  write data_in this cycle.
- pop  input  1  remove one entry this cycle.
- mode  input  1  0 = LIFO (pop newest), 1 = FIFO (pop oldest); sampled per cycle.
- data_in  input  DATA_WIDTH  push data.
- data_out  output  DATA_WIDTH  popped entry, registered.
- data_valid  output  1  one-cycle strobe, data_out updated by a successful pop.
- stack_full  output  1  count == DEPTH.
- stack_empty  output  1  count == 0.
- stack_threshold  output  1  count >= THRESHOLD.
- error  output  1  one-cycle pulse on an illegal request.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=0, async): rd_ptr=0, wr_ptr=0, count=0, data_out=0, data_valid=0, stack_empty=1, stack_full=0, stack_threshold=0, error=0. Memory is not reset.
- Pointers are $clog2(DEPTH) bits; increment from DEPTH-1 wraps to 0, decrement from 0 wraps to DEPTH-1.
- Push only, not full: mem[wr_ptr]<=data_in; wr_ptr++; count++.
- Pop only, not empty, FIFO: data_out<=mem[rd_ptr]; rd_ptr++; count--; data_valid=1 next cycle.
- Pop only, not empty, LIFO: data_out<=mem[wr_ptr-1]; wr_ptr--; count--; data_valid=1.
- Latency: data_out/data_valid valid on the cycle after the pop edge. Flags and count update on the same edge as the request.
- Push+pop, count in 1..DEPTH, FIFO: read mem[rd_ptr], write mem[wr_ptr], both pointers ++, count unchanged.
- Push+pop, count in 1..DEPTH, LIFO: data_out<=old top mem[wr_ptr-1]; data_in overwrites that slot; wr_ptr and count unchanged.
- Push+pop when full: legal in both modes, per the rules above; no error.
- Push+pop when empty: push executes; pop rejected; error=1; data_valid=0.
- Push when full (no pop): ignored, error=1, state unchanged.
- Pop when empty: ignored, error=1, data_valid=0, data_out holds its value.
- Mode may change at any time, including non-empty. Contents are order-preserved; the next pop uses the new mode.
- Reset mid-operation: immediate clear per the reset list; any in-flight data_valid is dropped.
- Flags are decoded from the registered count (glitch-free).

Optional Feature:
- Macro LIFO_FIFO_OVERWRITE_EN.
- Defined: push when full with no pop drops the oldest entry. mem[wr_ptr]<=data_in; wr_ptr++; rd_ptr++; count stays DEPTH; no error. Pop-when-empty still errors.
- Undefined: push when full is rejected with an error pulse, as above.

Decomposition:
- Package lifo_fifo_pkg:
  - mode constants MODE_LIFO=1'b0, MODE_FIFO=1'b1;
  - functions ptr_inc/ptr_dec (modulo DEPTH, parametrised width);
  - count-width helper.
- One sub-module: buf_ptr_ctr, a modulo-DEPTH up/down pointer register with async active-low reset. Instantiated for rd_ptr and wr_ptr.
- Storage array and flag logic live in the top level.

Test Plan (defaults W=3, D=5, T=3):
- Reset, then push 1,2,3,4,5 with mode=1 -> count=5, full=1, threshold=1 from the 3rd push. Pops return 1,2,3,4,5 with data_valid one cycle after each pop; empty=1 at end.
- Same pushes with mode=0 -> pops return 5,4,3,2,1.
- Wrap test, FIFO: push 5, pop 3, push 6,7,0 -> pointers wrap past index 4. Pops return 4,5,6,7,0.
- Simultaneous, LIFO, contents {1,2}, push=7+pop -> data_out=2, count=2; next pop returns 7.
- Simultaneous, FIFO, full {1..5}, push=6+pop -> data_out=1, full stays 1, no error. Later, pop on empty or push on full (macro off) -> error pulse of exactly 1 cycle, count unchanged.
- Mid-op reset: assert rst=0 between edges while count=4 -> all outputs reach reset values without a clock. With LIFO_FIFO_OVERWRITE_EN, full {1..5} + push 6 -> FIFO pops yield 2,3,4,5,6, no error.
